// File: rtl/sonic_eth_line_lb_backpressure_adapter.sv
// Valid-only to ready/valid adapter for the 10G line-loopback path: a show-ahead FIFO
// absorbs sink stalls, and words arriving while it is full are dropped and counted.
module sonic_eth_line_lb_backpressure_adapter #(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH:0]   fill_level_o,
    output logic                  overflow_o,
    input  logic                  clear_overflow_i,
    output logic [15:0]           drop_count_o
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  pop, push, drop;

    always_comb begin
        pop  = (fill_q != '0) && out_ready_i;
        // A full FIFO still accepts a word in the cycle its head leaves.
        push = in_valid_i && ((fill_q < FULL_LEVEL) || pop);
        drop = in_valid_i && !push;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end

        // A drop in the same cycle as a clear takes precedence.
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d   = 1'b1;
            if (clear_overflow_i) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (clear_overflow_i) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is never reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign out_valid_o  = (fill_q != '0);
    assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fill_level_o = fill_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_sonic_eth_line_lb_backpressure_adapter.sv
// Directed bench for the line-loopback backpressure adapter: ordering, stalls, drops,
// counter saturation and asynchronous reset.
module tb_sonic_eth_line_lb_backpressure_adapter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [71:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [71:0] out_data;
    logic [4:0]  fill_level;
    logic        overflow;
    logic        clear_overflow;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    sonic_eth_line_lb_backpressure_adapter #(
        .DATA_WIDTH(72),
        .DEPTH     (16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .in_valid_i      (in_valid),
        .in_data_i       (in_data),
        .out_ready_i     (out_ready),
        .out_valid_o     (out_valid),
        .out_data_o      (out_data),
        .fill_level_o    (fill_level),
        .overflow_o      (overflow),
        .clear_overflow_i(clear_overflow),
        .drop_count_o    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 72'h0 || fill_level !== 5'd0 ||
            overflow !== 1'b0 || drop_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%h fill=%0d ovf=%b drops=%0d, required all zero",
                     out_valid, out_data, fill_level, overflow, drop_count);
        end
        step();
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 72'(i);
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 72'(i) || fill_level !== 5'd1 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL passthrough_%0d: valid=%b data=%h fill=%0d ovf=%b, required 1 %h 1 0",
                         i, out_valid, out_data, fill_level, overflow, 72'(i));
            end
            $display("passthrough word %0d -> out_data=%h", i, out_data);
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 72'h0 || fill_level !== 5'd0) begin
            n_err++;
            $display("FAIL passthrough_empty: valid=%b data=%h fill=%0d, required 0 0 0",
                     out_valid, out_data, fill_level);
        end
    endtask

    task automatic test_fill_and_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = 72'h100 + 72'(i);
            step();
            if (i == 15) begin
                n_cmp++;
                if (fill_level !== 5'd16 || out_valid !== 1'b1 || out_data !== 72'h100 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_full: fill=%0d valid=%b data=%h ovf=%b, required 16 1 100 0",
                             fill_level, out_valid, out_data, overflow);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || drop_count !== 16'd2 || fill_level !== 5'd16 || out_data !== 72'h100) begin
            n_err++;
            $display("FAIL overflow_two: ovf=%b drops=%0d fill=%0d data=%h, required 1 2 16 100",
                     overflow, drop_count, fill_level, out_data);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 72'h100 + 72'(j)) begin
                n_err++;
                $display("FAIL drain_%0d: valid=%b data=%h, required 1 %h",
                         j, out_valid, out_data, 72'h100 + 72'(j));
            end
            step();
        end
        n_cmp++;
        if (fill_level !== 5'd0 || out_valid !== 1'b0 || out_data !== 72'h0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty: fill=%0d valid=%b data=%h ovf=%b, required 0 0 0 1",
                     fill_level, out_valid, out_data, overflow);
        end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL clear_after_drain: ovf=%b drops=%0d, required 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_full_streaming();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 72'h200 + 72'(i);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 72'h210 + 72'(k);
            n_cmp++;
            if (out_data !== 72'h200 + 72'(k)) begin
                n_err++;
                $display("FAIL stream_head_%0d: data=%h, required %h", k, out_data, 72'h200 + 72'(k));
            end
            step();
            n_cmp++;
            if (fill_level !== 5'd16 || drop_count !== 16'd0 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL stream_full_%0d: fill=%0d drops=%0d ovf=%b, required 16 0 0",
                         k, fill_level, drop_count, overflow);
            end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 72'h208 + 72'(j)) begin
                n_err++;
                $display("FAIL stream_drain_%0d: valid=%b data=%h, required 1 %h",
                         j, out_valid, out_data, 72'h208 + 72'(j));
            end
            step();
        end
        n_cmp++;
        if (fill_level !== 5'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_empty: fill=%0d valid=%b, required 0 0", fill_level, out_valid);
        end
    endtask

    task automatic test_alternating_ready();
        logic [71:0] q[$];
        logic [71:0] held;
        logic [71:0] exp_head;
        logic        rdy, was_valid, pop, push;
        for (int c = 0; c < 30; c++) begin
            rdy       = (c % 2 == 0);
            out_ready = rdy;
            in_valid  = 1'b1;
            in_data   = 72'h300 + 72'(c);
            exp_head  = (q.size() != 0) ? q[0] : 72'h0;
            n_cmp++;
            if (out_data !== exp_head) begin
                n_err++;
                $display("FAIL alt_head_%0d: data=%h, required %h", c, out_data, exp_head);
            end
            held      = out_data;
            was_valid = out_valid;
            pop       = rdy && (q.size() != 0);
            push      = (q.size() < 16) || pop;
            step();
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(72'h300 + 72'(c));
            n_cmp++;
            if (fill_level !== 5'((c + 1) / 2 + 1)) begin
                n_err++;
                $display("FAIL alt_fill_%0d: fill=%0d, required %0d", c, fill_level, (c + 1) / 2 + 1);
            end
            if (!rdy && was_valid) begin
                n_cmp++;
                if (out_data !== held) begin
                    n_err++;
                    $display("FAIL alt_stable_%0d: data=%h, required held %h", c, out_data, held);
                end
            end
        end
        n_cmp++;
        if (fill_level !== 5'd16 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL alt_final: fill=%0d drops=%0d, required 16 0", fill_level, drop_count);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 72'hDEAD;
        for (int i = 0; i < 65534; i++) step();
        n_cmp++;
        if (drop_count !== 16'hFFFE || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sat_before: drops=%h ovf=%b, required fffe 1", drop_count, overflow);
        end
        for (int i = 0; i < 70000 - 65534; i++) step();
        n_cmp++;
        if (drop_count !== 16'hFFFF || overflow !== 1'b1 || fill_level !== 5'd16) begin
            n_err++;
            $display("FAIL sat_hold: drops=%h ovf=%b fill=%0d, required ffff 1 16",
                     drop_count, overflow, fill_level);
        end
        in_valid       = 1'b0;
        clear_overflow = 1'b1;
        step();
        n_cmp++;
        if (drop_count !== 16'h0 || overflow !== 1'b0 || fill_level !== 5'd16) begin
            n_err++;
            $display("FAIL sat_clear: drops=%h ovf=%b fill=%0d, required 0 0 16",
                     drop_count, overflow, fill_level);
        end
        in_valid = 1'b1;
        step();
        n_cmp++;
        if (drop_count !== 16'd1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL clear_vs_drop: drops=%h ovf=%b, required 1 1", drop_count, overflow);
        end
        in_valid       = 1'b0;
        clear_overflow = 1'b0;
        $display("saturation sequence done, drops=%0d", drop_count);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 7; i++) step();
        out_ready = 1'b0;
        n_cmp++;
        if (fill_level !== 5'd9 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_fill: fill=%0d valid=%b, required 9 1", fill_level, out_valid);
        end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 72'h0 || fill_level !== 5'd0 ||
            overflow !== 1'b0 || drop_count !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b data=%h fill=%0d ovf=%b drops=%0d, required all zero",
                     out_valid, out_data, fill_level, overflow, drop_count);
        end
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 72'h0 || fill_level !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: valid=%b data=%h fill=%0d, required 0 0 0",
                     out_valid, out_data, fill_level);
        end
        in_valid = 1'b1;
        in_data  = 72'h400;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 72'h400 || fill_level !== 5'd1) begin
            n_err++;
            $display("FAIL post_reset_word: valid=%b data=%h fill=%0d, required 1 400 1",
                     out_valid, out_data, fill_level);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 72'h0 || fill_level !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_drain: valid=%b data=%h fill=%0d, required 0 0 0",
                     out_valid, out_data, fill_level);
        end
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        test_reset();
        test_passthrough();
        test_fill_and_overflow();
        test_full_streaming();
        test_alternating_ready();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
